// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the scoreboarded register file: default geometry
// constants and the state encoding of the clear-sweep FSM.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Busy-bit vector for the register file. A register is marked busy by an
// accepted reservation and released by an accepted write; the clear sweep
// zeroes one busy bit per cycle.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   reserve_valid   reservation request for reserve_addr
//   reserve_addr    register to reserve
//   reserve_ready   reservation can be accepted this cycle
//   write_accept    write qualified by the top (not clearing, not r0-ignored)
//   write_addr      write target
//   clear_active    clear sweep in progress
//   clear_idx       register zeroed by the sweep this cycle
//   busy            raw busy vector, one bit per register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              reserve_ready,
  input  logic              write_accept,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              clear_active,
  input  logic [ADDR_W-1:0] clear_idx,
  output logic [DEPTH-1:0]  busy
);

  logic res_set;

  assign reserve_ready = !clear_active && !busy[reserve_addr];

  // r0 still handshakes when hardwired to zero, it just never becomes busy.
  assign res_set = reserve_valid && reserve_ready &&
                   !((ZERO_REG != 0) && (reserve_addr == '0));

  // Set is applied after release so a same-cycle reserve and write to one
  // (non-busy) register leaves it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (clear_active) begin
      busy[clear_idx] <= 1'b0;
    end else begin
      if (write_accept) busy[write_addr]   <= 1'b0;
      if (res_set)      busy[reserve_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Register file with a per-register busy scoreboard, optional write-to-read
// forwarding, optional hardwired-zero r0, and a sequential clear sweep that
// zeroes one register (data and busy) per cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   write_enable/addr/data     write port (takes effect at next edge)
//   read_addr1/2               combinational read addresses
//   read_data1/2, read_busy1/2 read values and their busy bits
//   reserve_valid/addr/ready   reservation handshake
//   clear_req, clear_busy      start / status of the clear sweep
//   debug_data                 contents of register DEBUG_IDX
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_REG  = 0,
  parameter int BYPASS    = 1,
  parameter int DEBUG_IDX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  output logic              reserve_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [DATA_W-1:0] debug_data
);

  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DBG   = ADDR_W'(DEBUG_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              write_accept;

  assign clearing   = (state == ST_CLEAR);
  assign clear_busy = clearing;

  // Writes are dropped during the sweep and, with ZERO_REG, to r0.
  assign write_accept = write_enable && !clearing &&
                        !((ZERO_REG != 0) && (write_addr == '0));

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
    return (BYPASS != 0) && write_accept && (write_addr == a);
  endfunction

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .reserve_valid (reserve_valid),
    .reserve_addr  (reserve_addr),
    .reserve_ready (reserve_ready),
    .write_accept  (write_accept),
    .write_addr    (write_addr),
    .clear_active  (clearing),
    .clear_idx     (cnt),
    .busy          (busy)
  );

  // Clear sweep: DEPTH cycles in ST_CLEAR, counter wraps to 0 on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (clearing) begin
      regs[cnt] <= '0;
    end else if (write_accept) begin
      regs[write_addr] <= write_data;
    end
  end

  always_comb begin
    read_data1 = regs[read_addr1];
    read_busy1 = busy[read_addr1];
    if (is_zero_reg(read_addr1)) begin
      read_data1 = '0;
      read_busy1 = 1'b0;
    end else if (fwd_hit(read_addr1)) begin
      read_data1 = write_data;
      read_busy1 = 1'b0;
    end

    read_data2 = regs[read_addr2];
    read_busy2 = busy[read_addr2];
    if (is_zero_reg(read_addr2)) begin
      read_data2 = '0;
      read_busy2 = 1'b0;
    end else if (fwd_hit(read_addr2)) begin
      read_data2 = write_data;
      read_busy2 = 1'b0;
    end
  end

  assign debug_data = regs[DBG];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Two instances share one stimulus: dut_a uses defaults (BYPASS=1,
// ZERO_REG=0), dut_z uses ZERO_REG=1, BYPASS=0. A vector table drives the
// basic read/write/reserve behaviour through a scoreboard queue; hand-written
// sequences cover the clear sweep and reset during a sweep.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [31:0] write_data;
  logic [2:0]  read_addr1, read_addr2;
  logic        reserve_valid;
  logic [2:0]  reserve_addr;
  logic        clear_req;

  logic [31:0] a_rd1, a_rd2, a_dbg, z_rd1, z_rd2, z_dbg;
  logic        a_b1, a_b2, a_rdy, a_cb, z_b1, z_b2, z_rdy, z_cb;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1), .DEBUG_IDX(1)) dut_a (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(a_rd1), .read_data2(a_rd2), .read_busy1(a_b1), .read_busy2(a_b2),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(a_rdy),
    .clear_req(clear_req), .clear_busy(a_cb), .debug_data(a_dbg)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0), .DEBUG_IDX(1)) dut_z (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(z_rd1), .read_data2(z_rd2), .read_busy1(z_b1), .read_busy2(z_b2),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(z_rdy),
    .clear_req(clear_req), .clear_busy(z_cb), .debug_data(z_dbg)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic        rv;
    logic [2:0]  rsa;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic [31:0] dbg;
    logic [31:0] zrd1;
    logic [31:0] zrd2;
    logic        zb1;
    logic        zrdy;
  } vec_t;

  vec_t tbl [14];
  vec_t sb_q [$];
  int   row_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2, input logic rv,
                       input logic [2:0] rsa, input logic clr);
    write_enable  = we;
    write_addr    = wa;
    write_data    = wd;
    read_addr1    = r1;
    read_addr2    = r2;
    reserve_valid = rv;
    reserve_addr  = rsa;
    clear_req     = clr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compare the expected record for the current cycle.
  always @(negedge clk) begin : sb_check
    vec_t e;
    int   r;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      r = row_q.pop_front();
      check($sformatf("tbl_a[%0d]", r),
            128'({a_rd1, a_rd2, a_b1, a_b2, a_rdy, a_dbg}),
            128'({e.rd1, e.rd2, e.b1, e.b2, e.rdy, e.dbg}));
      check($sformatf("tbl_z[%0d]", r),
            128'({z_rd1, z_rd2, z_b1, z_rdy, z_dbg}),
            128'({e.zrd1, e.zrd2, e.zb1, e.zrdy, e.dbg}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cb_cnt;

    //        we wa wd            ra1 ra2 rv rsa | rd1           rd2           b1 b2 rdy dbg          | zrd1          zrd2          zb1 zrdy
    tbl[0]  = '{0, 0, 32'h0,        0, 0, 0, 0,   32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 1};
    tbl[1]  = '{1, 3, 32'hDEADBEEF, 3, 1, 0, 0,   32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 1};
    tbl[2]  = '{0, 0, 32'h0,        3, 1, 0, 0,   32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1};
    tbl[3]  = '{1, 2, 32'h55,       3, 2, 0, 0,   32'hDEADBEEF, 32'h55,       0, 0, 1, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1};
    tbl[4]  = '{0, 0, 32'h0,        4, 2, 1, 4,   32'h0,        32'h55,       0, 0, 1, 32'h0,        32'h0,        32'h55,       0, 1};
    tbl[5]  = '{0, 0, 32'h0,        4, 2, 1, 4,   32'h0,        32'h55,       1, 0, 0, 32'h0,        32'h0,        32'h55,       1, 0};
    tbl[6]  = '{1, 4, 32'h7,        4, 3, 0, 4,   32'h7,        32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0};
    tbl[7]  = '{0, 0, 32'h0,        4, 1, 0, 4,   32'h7,        32'h0,        0, 0, 1, 32'h0,        32'h7,        32'h0,        0, 1};
    tbl[8]  = '{1, 1, 32'h1234,     1, 0, 1, 1,   32'h1234,     32'h0,        0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 1};
    tbl[9]  = '{0, 0, 32'h0,        1, 0, 0, 1,   32'h1234,     32'h0,        1, 0, 0, 32'h1234,     32'h1234,     32'h0,        1, 0};
    tbl[10] = '{1, 0, 32'hFF,       0, 0, 1, 0,   32'hFF,       32'hFF,       0, 0, 1, 32'h1234,     32'h0,        32'h0,        0, 1};
    tbl[11] = '{0, 0, 32'h0,        0, 0, 0, 0,   32'hFF,       32'hFF,       1, 1, 0, 32'h1234,     32'h0,        32'h0,        0, 1};
    tbl[12] = '{1, 0, 32'hAB,       0, 5, 0, 0,   32'hAB,       32'h0,        0, 0, 0, 32'h1234,     32'h0,        32'h0,        0, 1};
    tbl[13] = '{0, 0, 32'h0,        0, 4, 0, 0,   32'hAB,       32'h7,        0, 0, 1, 32'h1234,     32'h0,        32'h7,        0, 1};

    // Reset state, both during and just after reset.
    reset = 1'b1;
    idle();
    #12;
    check("reset_during_a", 128'({a_rd1, a_rd2, a_b1, a_b2, a_rdy, a_cb, a_dbg}),
          128'({32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0}));
    check("reset_during_z", 128'({z_rd1, z_rd2, z_b1, z_b2, z_rdy, z_cb, z_dbg}),
          128'({32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_after_a", 128'({a_rd1, a_b1, a_rdy, a_cb, a_dbg}),
          128'({32'h0, 1'b0, 1'b1, 1'b0, 32'h0}));

    // Table-driven vectors through the scoreboard queue.
    for (int i = 0; i < 14; i++) begin
      cyc();
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2,
            tbl[i].rv, tbl[i].rsa, 1'b0);
      sb_q.push_back(tbl[i]);
      row_q.push_back(i);
    end
    @(negedge clk);
    #1;
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    // Clear sweep: fill r0..r7 = 1..8, reserve r6, then sweep.
    for (int i = 0; i < 8; i++) begin
      cyc();
      drive(1'b1, 3'(i), 32'(i + 1), 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    end
    cyc();
    drive(1'b0, 3'd0, 32'h0, 3'd7, 3'd0, 1'b1, 3'd6, 1'b0);
    @(negedge clk);
    check("fill_r7_a", 128'(a_rd1), 128'(32'h8));
    cyc();
    drive(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    check("clear_req_cycle_idle", 128'({a_cb, z_cb}), 128'(2'b00));
    cb_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      // Write, reservation and a fresh clear_req are all ignored in the sweep.
      drive(1'b1, 3'd5, 32'h99, (k == 2) ? 3'd1 : 3'd6, 3'd2, 1'b1, 3'd7, 1'b1);
      @(negedge clk);
      if (a_cb && z_cb) cb_cnt++;
      if (k == 0) check("sweep_rdy_b1", 128'({a_rdy, z_rdy, a_b1}), 128'(3'b001));
      if (k == 2) check("sweep_partial", 128'({a_rd1, a_rd2, z_rd2}),
                        128'({32'h0, 32'h3, 32'h3}));
    end
    cyc();
    idle();
    @(negedge clk);
    check("sweep_len", 128'(cb_cnt), 128'(8));
    check("sweep_done", 128'({a_cb, z_cb, a_rdy}), 128'(3'b001));
    for (int i = 0; i < 8; i++) begin
      read_addr1 = 3'(i);
      read_addr2 = 3'(i);
      #1;
      check($sformatf("cleared_r%0d", i), 128'({a_rd1, a_b1, a_b2, z_rd1, z_b1}),
            128'({32'h0, 1'b0, 1'b0, 32'h0, 1'b0}));
    end
    check("cleared_dbg", 128'({a_dbg, z_dbg}), 128'(64'h0));

    // Reset in the middle of a sweep.
    cyc();
    drive(1'b1, 3'd7, 32'h77, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    drive(1'b1, 3'd1, 32'h11, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0);
    cyc();
    drive(1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      drive(1'b0, 3'd0, 32'h0, 3'd7, 3'd3, 1'b0, 3'd3, 1'b0);
    end
    #1;
    check("mid_sweep_state", 128'({a_cb, a_rd1, a_b2}), 128'({1'b1, 32'h77, 1'b1}));
    reset = 1'b1;
    #1;
    check("abort_a", 128'({a_cb, a_rdy, a_b2, a_rd1, a_dbg}),
          128'({1'b0, 1'b1, 1'b0, 32'h0, 32'h0}));
    check("abort_z", 128'({z_cb, z_rdy, z_b2, z_rd1, z_dbg}),
          128'({1'b0, 1'b1, 1'b0, 32'h0, 32'h0}));
    @(negedge clk);
    reset = 1'b0;
    cb_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      idle();
      @(negedge clk);
      if (a_cb || z_cb) cb_cnt++;
    end
    check("no_resume", 128'(cb_cnt), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
